reset_sequencer: RTL and testbench

- Consumes the power-up/system reset pulse and produces ordered, synchronously released reset outputs for the Hack subsystems.
- Reset domains, default ordering: 0 = memory/ROM, 1 = CPU, 2 = I/O.
- Reset assertion is asynchronous. Release goes through a synchronizer, a stretch period, then one domain at a time, each gated by that domain's ready acknowledge.
- A synchronous soft_reset (e.g. a memory-mapped reset key) restarts the sequence without the async path.

---
 rtl/hack_reset_pkg.sv | 28 ++
 rtl/reset_sync.sv | 23 ++
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/hack_reset_pkg.sv
// Shared definitions for the Hack reset sequencer: FSM states, default
// parameter values and the width of the shared sequencing counter.
package hack_reset_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HOLD,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STRETCH     = 4;
    localparam int DEF_NUM_DOMAINS = 3;
    localparam int DEF_GAP         = 2;
    localparam int DEF_TIMEOUT     = 16;

    // One counter serves HOLD, WAIT and GAP, so it must hold the largest limit.
    function automatic int cnt_width(input int stretch, input int gap, input int timeout);
        int m;
        m = stretch;
        if (gap > m) m = gap;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchronizer, reusable across Hack blocks.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rst_sync
);

    logic [STAGES-1:0] r_sync;

    // Zeros shift in from the bottom; the top stage is the synchronized reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], 1'b0};
        end
    end

    assign o_rst_sync = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases the Hack reset domains one at a time after a synchronized, stretched
// power-up reset, waiting on each domain's ready (with timeout) before the next.
module reset_sequencer
    import hack_reset_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STRETCH     = DEF_STRETCH,
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int GAP         = DEF_GAP,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_reset,
    input  logic [NUM_DOMAINS-1:0] dom_ready,
    output logic [NUM_DOMAINS-1:0] dom_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam int CNT_W = cnt_width(STRETCH, GAP, TIMEOUT);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_DOM     = IDX_W'(NUM_DOMAINS - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_nx;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [IDX_W-1:0]       r_dom_idx;
    logic [IDX_W-1:0]       w_idx_nx;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [NUM_DOMAINS-1:0] r_dom_reset;
    logic [NUM_DOMAINS-1:0] w_dom_reset_nx;
    logic                   r_busy;
    logic                   w_busy_nx;
    logic                   r_done;
    logic                   w_done_nx;
    logic                   r_timeout_err;
    logic                   w_timeout_nx;
    logic                   w_sync_rst;

    reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .i_clk     (clk),
        .i_rst     (reset),
        .o_rst_sync(w_sync_rst)
    );

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_idx_inc = r_dom_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_SYNC;
            r_cnt         <= '0;
            r_dom_idx     <= '0;
            r_dom_reset   <= '1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_dom_idx     <= w_idx_nx;
            r_dom_reset   <= w_dom_reset_nx;
            r_busy        <= w_busy_nx;
            r_done        <= w_done_nx;
            r_timeout_err <= w_timeout_nx;
        end
    end

    // The counter restarts from zero on every state entry, so it never wraps.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_idx_nx       = r_dom_idx;
        w_dom_reset_nx = r_dom_reset;
        w_busy_nx      = r_busy;
        w_done_nx      = r_done;
        w_timeout_nx   = r_timeout_err;

        if (soft_reset && (r_state != ST_SYNC)) begin
            w_state_nx     = ST_HOLD;
            w_cnt_nx       = '0;
            w_idx_nx       = '0;
            w_dom_reset_nx = '1;
            w_busy_nx      = 1'b1;
            w_done_nx      = 1'b0;
            w_timeout_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (!w_sync_rst) begin
                        w_state_nx = ST_HOLD;
                        w_cnt_nx   = '0;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == STRETCH_LAST) begin
                        w_state_nx        = ST_WAIT;
                        w_cnt_nx          = '0;
                        w_idx_nx          = '0;
                        w_dom_reset_nx[0] = 1'b0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (dom_ready[r_dom_idx]) begin
                        w_state_nx = ST_GAP;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_state_nx   = ST_GAP;
                        w_cnt_nx     = '0;
                        w_timeout_nx = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nx = '0;
                        if (r_dom_idx == LAST_DOM) begin
                            w_state_nx     = ST_DONE;
                            w_dom_reset_nx = '0;
                            w_busy_nx      = 1'b0;
                            w_done_nx      = 1'b1;
                        end else begin
                            w_state_nx                = ST_WAIT;
                            w_idx_nx                  = w_idx_inc;
                            w_dom_reset_nx[w_idx_inc] = 1'b0;
                        end
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    w_dom_reset_nx = '0;
                end
                default: begin
                    w_state_nx = ST_SYNC;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    assign dom_reset   = r_dom_reset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: expected output timelines are derived
// from the release-edge schedule and queued ahead of each sampled clock edge.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       soft_reset;
    logic [2:0] dom_ready;
    logic [2:0] dom_reset;
    logic       busy;
    logic       done;
    logic       timeout_err;

    logic [5:0] expQ[$];
    int         numCompared;
    int         numMismatched;

    reset_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .dom_ready  (dom_ready),
        .dom_reset  (dom_reset),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got {dom_reset,busy,done,terr}=%b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic popCheck(input string tag);
        logic [5:0] e;
        e = expQ.pop_front();
        checkOutput(tag, {dom_reset, busy, done, timeout_err}, e);
    endtask

    // Output vector after edge k, given the edges where each domain releases,
    // where DONE is entered and where timeout_err sets (-1 = never).
    function automatic logic [5:0] expAt(input int k, input int r0, input int r1,
                                         input int r2, input int dn, input int to);
        logic [2:0] dr;
        dr[0] = (k < r0);
        dr[1] = (k < r1);
        dr[2] = (k < r2);
        return {dr, (k < dn), (k >= dn), ((to >= 0) && (k >= to))};
    endfunction

    task automatic applyStimulus(input string tag, input int first, input int last,
                                 input int r0, input int r1, input int r2,
                                 input int dn, input int to);
        for (int k = first; k <= last; k++) begin
            expQ.push_back(expAt(k, r0, r1, r2, dn, to));
            @(posedge clk);
            #1;
            popCheck($sformatf("%s_e%0d", tag, k));
        end
    endtask

    // Asserts reset between edges, checks it takes effect with no clock edge,
    // holds it for n edges, then releases on a falling edge so E0 follows.
    task automatic holdReset(input string tag, input int n);
        reset = 1'b1;
        #1;
        expQ.push_back(6'b111_1_0_0);
        popCheck({tag, "_async"});
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            expQ.push_back(6'b111_1_0_0);
            popCheck($sformatf("%s_hold%0d", tag, k));
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        reset         = 1'b0;
        soft_reset    = 1'b0;
        dom_ready     = 3'b111;
        #3;

        $display("[TB] power-up with all domains ready");
        holdReset("pwr", 3);
        applyStimulus("pwr", 0, 17, 6, 9, 12, 15, -1);

        $display("[TB] slow ready on domain 1");
        dom_ready = 3'b101;
        #2;
        holdReset("slow", 3);
        applyStimulus("slow", 0, 13, 6, 9, 16, 19, -1);
        dom_ready = 3'b111;
        applyStimulus("slow", 14, 21, 6, 9, 16, 19, -1);

        $display("[TB] domain 0 never ready");
        dom_ready = 3'b110;
        #2;
        holdReset("tmo", 3);
        applyStimulus("tmo", 0, 32, 6, 24, 27, 30, 22);

        $display("[TB] soft reset pulse in DONE");
        dom_ready  = 3'b111;
        soft_reset = 1'b1;
        applyStimulus("soft", 0, 0, 4, 7, 10, 13, -1);
        soft_reset = 1'b0;
        applyStimulus("soft", 1, 15, 4, 7, 10, 13, -1);

        $display("[TB] async reset while waiting on domain 1");
        dom_ready = 3'b101;
        #2;
        holdReset("mid", 2);
        applyStimulus("mid", 0, 11, 6, 9, 26, 29, -1);
        #2;
        dom_ready = 3'b111;
        holdReset("midrst", 2);
        applyStimulus("midrst", 0, 17, 6, 9, 12, 15, -1);

        $display("[TB] soft reset during SYNC is ignored");
        #2;
        holdReset("sync", 3);
        soft_reset = 1'b1;
        applyStimulus("sync", 0, 1, 6, 9, 12, 15, -1);
        soft_reset = 1'b0;
        applyStimulus("sync", 2, 17, 6, 9, 12, 15, -1);

        $display("[TB] soft reset held high in DONE");
        soft_reset = 1'b1;
        applyStimulus("held", 0, 9, 13, 16, 19, 22, -1);
        soft_reset = 1'b0;
        applyStimulus("held", 10, 24, 13, 16, 19, 22, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
